modn_updown_counter: RTL
========================

Name: modn_updown_counter

Overview:
Parametrised modulo-N up/down counter that generalises the fixed mod-8 up counter.
- Adds count direction, synchronous parallel load, a cascade terminal-count output, a registered wrap pulse and a stretched LED indicator.
- Sits in the lab/exam peripheral set: it drives board LEDs and 7-segment digit counters.
- Multiple instances can be cascaded through TC to build multi-digit counters.

Parameters:
- MODULUS, 8, count range 0..MODULUS-1; legal range 2..65536.
- W, $clog2(MODULUS), width of Q and D; derived; never overridden.
- LED_HOLD, 4, number of CLK cycles LED stays high after a wrap event; legal range 1..255.

Ports:
- CLK  input  1  clock; all state updates on the falling edge.
- RST  input  1  synchronous active-low reset.
- I  input  1  count enable.
- DIR  input  1  0 = count up, 1 = count down.
- LOAD  input  1  synchronous parallel load.
- D  input  W  load value.
- Q  output  W  current count (registered).
- TC  output  1  terminal-count decode for cascading (combinational from Q and DIR).
- WRAP  output  1  one-cycle registered wrap pulse.
- LED  output  1  stretched wrap indicator (registered).

Behaviour:
- Single clock CLK. Reset is synchronous and active-low: RST sampled low on a falling CLK edge gives Q=0, WRAP=0, LED=0 and clears the LED hold counter.
- Priority per edge: RST low > LOAD > I > hold.
- LOAD=1:
  - Q <= D if D < MODULUS, else Q <= MODULUS-1 (clamp).
  - No wrap event; WRAP <= 0.
  - LED hold counter is unaffected and continues to count down.
- I=1, LOAD=0, DIR=0 (up):
  - If Q == MODULUS-1: Q <= 0 and WRAP <= 1.
  - Otherwise Q <= Q+1 and WRAP <= 0.
- I=1, LOAD=0, DIR=1 (down):
  - If Q == 0: Q <= MODULUS-1 and WRAP <= 1.
  - Otherwise Q <= Q-1 and WRAP <= 0.
- I=0, LOAD=0: Q holds; WRAP <= 0.
- WRAP is high for exactly the one cycle following the wrapping edge.
- TC = (DIR==0 && Q==MODULUS-1) || (DIR==1 && Q==0).
  - TC is independent of I.
  - Cascade rule: next stage I = this stage's I & TC.
- Arithmetic:
  - Comparisons are done at W bits.
  - No intermediate value exceeds MODULUS-1.
  - When MODULUS is a power of 2, the wrap matches natural overflow; the explicit compare is still used.
- DIR may change on any cycle. It takes effect on the same edge; there is no pipeline.
- LED stretch:
  - On an edge where a wrap occurs, the hold counter loads LED_HOLD and LED <= 1.
  - Otherwise, if hold > 0, hold decrements; LED <= 1 while post-decrement hold > 0, else LED <= 0.
  - Result: LED is high for exactly LED_HOLD cycles after the wrap edge.
  - A wrap during an active stretch reloads the counter (retrigger).
- Reset mid-stretch: LED drops on the reset edge. Reset mid-count: Q=0 regardless of I, LOAD and DIR.
- Latency:
  - Q, WRAP and LED: 1 edge from the input sample.
  - TC: 0 cycles from Q.

Optional Feature:
- Macro: COUNT_SAT_EN.
- Defined: saturating mode.
  - Up at MODULUS-1 with I=1: Q holds at MODULUS-1 and WRAP <= 1 (overflow attempt).
  - Down at 0 with I=1: Q holds at 0 and WRAP <= 1.
  - LED stretch triggers on these WRAP events.
  - TC is unchanged.
- Undefined: wrap-around behaviour as above.

Decomposition:
- Package modn_counter_pkg:
  - Direction constants DIR_UP=1'b0 and DIR_DOWN=1'b1.
  - Width function clog2_min1 (returns ≥1).
  - LED hold counter width constant (8 bits).
- Sub-module led_stretch:
  - Parameter HOLD.
  - Ports CLK, RST, TRIG, LED.
  - Contains the hold counter and retrigger logic.
  - The top module instantiates it with TRIG = next-cycle wrap condition.

Test Plan:
- Reset and up-count: MODULUS=10, LED_HOLD=3, RST low 2 edges, then I=1 DIR=0 for 12 edges -> Q: 0,1..9,0,1,2; WRAP high only the cycle after the 9->0 edge; LED high exactly 3 cycles from that edge.
- Down-count wrap: LOAD with D=2 then I=1 DIR=1 -> Q 2,1,0,9,8; TC high while Q==0; WRAP pulse after the 0->9 edge.
- Load clamp and priority: D=13, LOAD=1, I=1 -> Q=9, WRAP=0; RST low with LOAD=1 -> Q=0.
- Retrigger: MODULUS=2, LED_HOLD=3, I=1 continuous -> wrap every 2 edges; LED never drops after the first wrap.
- Cascade: two instances with MODULUS=10 and the second I = I & TC0; run 100 edges -> {Q1,Q0} counts 00..99 then 00; check DIR=1 reverses correctly.
- COUNT_SAT_EN build: up from 7 with MODULUS=10 for 5 edges -> Q 8,9,9,9,9; WRAP high on the 3 hold cycles; non-SAT build wraps to 0.

Source files
------------

// File: rtl/modn_counter_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter family.
package modn_counter_pkg;

    // Count direction encodings on the DIR pin
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Width of the LED stretch hold counter (holds up to 255 cycles)
    localparam int LED_HOLD_W = 8;

    // Bits needed to hold 0..n-1, never less than one bit
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/modn_updown_counter_led_stretch.sv
// LED pulse stretcher: holds LED high for HOLD cycles after each trigger,
// reloading on a retrigger. State advances on the falling edge of CLK.
module led_stretch
    import modn_counter_pkg::*;
#(
    parameter int HOLD = 4
) (
    input  logic CLK,
    input  logic RST,
    input  logic TRIG,
    output logic LED
);

    localparam logic [LED_HOLD_W-1:0] HOLD_V  = LED_HOLD_W'(HOLD);
    localparam logic [LED_HOLD_W-1:0] ZERO_H  = LED_HOLD_W'(0);
    localparam logic [LED_HOLD_W-1:0] ONE_H   = LED_HOLD_W'(1);

    logic [LED_HOLD_W-1:0] hold_r;
    logic [LED_HOLD_W-1:0] hold_next_s;
    logic                  led_r;
    logic                  led_next_s;

    // Next hold count and LED level: trigger reloads, otherwise count down to zero
    always_comb begin
        hold_next_s = hold_r;
        led_next_s  = 1'b0;
        if (TRIG) begin
            hold_next_s = HOLD_V;
            led_next_s  = 1'b1;
        end else if (hold_r != ZERO_H) begin
            hold_next_s = hold_r - ONE_H;
            led_next_s  = (hold_next_s != ZERO_H);
        end else begin
            hold_next_s = hold_r;
            led_next_s  = 1'b0;
        end
    end

    // Hold counter and LED register with synchronous active-low reset
    always_ff @(negedge CLK) begin
        if (!RST) begin
            hold_r <= ZERO_H;
            led_r  <= 1'b0;
        end else begin
            hold_r <= hold_next_s;
            led_r  <= led_next_s;
        end
    end

    assign LED = led_r;

endmodule

// File: rtl/modn_updown_counter.sv
// Modulo-N up/down counter with parallel load, cascade TC, wrap pulse and
// stretched LED. Define COUNT_SAT_EN to saturate at the ends instead of wrapping.
module modn_updown_counter
    import modn_counter_pkg::*;
#(
    parameter int  MODULUS  = 8,
    parameter int  LED_HOLD = 4,
    localparam int W        = clog2_min1(MODULUS)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         I,
    input  logic         DIR,
    input  logic         LOAD,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q,
    output logic         TC,
    output logic         WRAP,
    output logic         LED
);

    localparam logic [W-1:0] MAX_Q  = W'(MODULUS - 1);
    localparam logic [W-1:0] ZERO_Q = W'(0);
    localparam logic [W-1:0] ONE_Q  = W'(1);

    logic [W-1:0] q_r;
    logic [W-1:0] q_next_s;
    logic [W-1:0] load_val_s;
    logic         wrap_r;
    logic         wrap_next_s;
    logic         led_s;

    // Load clamp only exists when D can encode values at or above MODULUS
    if (MODULUS == (1 << W)) begin : g_noclamp
        assign load_val_s = D;
    end else begin : g_clamp
        assign load_val_s = (D > MAX_Q) ? MAX_Q : D;
    end

    // Next count and wrap condition: LOAD beats I, otherwise hold
    always_comb begin
        q_next_s    = q_r;
        wrap_next_s = 1'b0;
        if (LOAD) begin
            q_next_s    = load_val_s;
            wrap_next_s = 1'b0;
        end else if (I) begin
            if (DIR == DIR_UP) begin
                if (q_r == MAX_Q) begin
`ifdef COUNT_SAT_EN
                    q_next_s = MAX_Q;
`else
                    q_next_s = ZERO_Q;
`endif
                    wrap_next_s = 1'b1;
                end else begin
                    q_next_s = q_r + ONE_Q;
                end
            end else begin
                if (q_r == ZERO_Q) begin
`ifdef COUNT_SAT_EN
                    q_next_s = ZERO_Q;
`else
                    q_next_s = MAX_Q;
`endif
                    wrap_next_s = 1'b1;
                end else begin
                    q_next_s = q_r - ONE_Q;
                end
            end
        end else begin
            q_next_s    = q_r;
            wrap_next_s = 1'b0;
        end
    end

    // Count and wrap-pulse registers with synchronous active-low reset
    always_ff @(negedge CLK) begin
        if (!RST) begin
            q_r    <= ZERO_Q;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next_s;
            wrap_r <= wrap_next_s;
        end
    end

    led_stretch #(
        .HOLD (LED_HOLD)
    ) u_led_stretch (
        .CLK  (CLK),
        .RST  (RST),
        .TRIG (wrap_next_s),
        .LED  (led_s)
    );

    assign Q    = q_r;
    assign WRAP = wrap_r;
    assign LED  = led_s;
    assign TC   = ((DIR == DIR_UP) && (q_r == MAX_Q)) ||
                  ((DIR == DIR_DOWN) && (q_r == ZERO_Q));

endmodule
